// File: rtl/string_to_board.sv
// string_to_board: parses an ASCII text stream of ROWS lines x COLS decimal
// fields back into the packed board vector. Cell values build up in a shadow
// copy of the board. The visible board is replaced in one cycle when the last
// row of a frame is complete.
module string_to_board #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int CELL_W = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    char_in,
    input  logic                          char_valid,
    output logic [ROWS*COLS*CELL_W-1:0]   board,
    output logic                          board_valid,
    output logic                          parse_err,
    output logic                          busy
);

    localparam int BOARD_W = ROWS * COLS * CELL_W;
    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int IDX_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    // Four guard bits hold acc*10+9 without wrapping, so an overflow is seen.
    localparam int ACC_W   = CELL_W + 4;

    localparam logic [COL_W-1:0] COLS_C     = COL_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW_C = ROW_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] COLS_IDX_C = IDX_W'(COLS);

    typedef enum logic [1:0] {
        ST_SEP = 2'd0,
        ST_NUM = 2'd1,
        ST_DOT = 2'd2,
        ST_ERR = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CELL_W-1:0]    acc_q, acc_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [BOARD_W-1:0]   shadow_q, shadow_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic                 board_valid_q, board_valid_d;
    logic                 parse_err_q, parse_err_d;
    logic                 busy_q, busy_d;

    logic                 is_digit_s, is_dot_s, is_sep_s, is_nl_s, is_cr_s;
    logic [3:0]           digit_s;
    logic [ACC_W-1:0]     acc_ext_s, acc_mul_s;
    logic                 acc_ovf_s;
    logic [IDX_W-1:0]     cell_idx_s;

    // Character classification, decimal accumulate step and shadow cell index
    always_comb begin
        is_digit_s = (char_in >= 8'h30) && (char_in <= 8'h39);
        is_dot_s   = (char_in == 8'h2E);
        is_sep_s   = (char_in == 8'h20) || (char_in == 8'h7C);
        is_nl_s    = (char_in == 8'h0A);
        is_cr_s    = (char_in == 8'h0D);
        digit_s    = char_in[3:0];
        acc_ext_s  = {4'd0, acc_q};
        acc_mul_s  = (acc_ext_s << 3) + (acc_ext_s << 1) + {{(ACC_W-4){1'b0}}, digit_s};
        acc_ovf_s  = (acc_mul_s[ACC_W-1:CELL_W] != 4'd0);
        cell_idx_s = IDX_W'(row_q) * COLS_IDX_C + IDX_W'(col_q);
    end

    // Parser next state: field store, end-of-row check, commit and error entry
    always_comb begin
        logic              store_v;
        logic              eor_v;
        logic              err_v;
        logic [CELL_W-1:0] store_val_v;
        logic [COL_W-1:0]  col_v;

        state_d       = state_q;
        acc_d         = acc_q;
        row_d         = row_q;
        col_d         = col_q;
        shadow_d      = shadow_q;
        board_d       = board_q;
        board_valid_d = 1'b0;
        parse_err_d   = 1'b0;
        busy_d        = busy_q;
        store_v       = 1'b0;
        eor_v         = 1'b0;
        err_v         = 1'b0;
        store_val_v   = {CELL_W{1'b0}};
        col_v         = col_q;

        if (char_valid && !is_cr_s) begin
            // The first significant character of a frame marks it in progress;
            // a blank line at the frame start does not.
            if ((state_q == ST_SEP) && (row_q == {ROW_W{1'b0}}) &&
                (col_q == {COL_W{1'b0}}) && !is_nl_s) begin
                busy_d = 1'b1;
            end else begin
                busy_d = busy_q;
            end

            case (state_q)
                ST_SEP: begin
                    if (is_digit_s) begin
                        acc_d   = {{(CELL_W-4){1'b0}}, digit_s};
                        state_d = ST_NUM;
                    end else if (is_dot_s) begin
                        state_d = ST_DOT;
                    end else if (is_sep_s) begin
                        state_d = ST_SEP;
                    end else if (is_nl_s) begin
                        // A newline with no fields on the line is a blank line.
                        eor_v = (col_q != {COL_W{1'b0}});
                    end else begin
                        err_v = 1'b1;
                    end
                end
                ST_NUM: begin
                    if (is_digit_s) begin
                        if (acc_ovf_s) begin
                            err_v = 1'b1;
                        end else begin
                            acc_d = acc_mul_s[CELL_W-1:0];
                        end
                    end else if (is_sep_s) begin
                        store_v     = 1'b1;
                        store_val_v = acc_q;
                        state_d     = ST_SEP;
                    end else if (is_nl_s) begin
                        store_v     = 1'b1;
                        store_val_v = acc_q;
                        eor_v       = 1'b1;
                        state_d     = ST_SEP;
                    end else begin
                        err_v = 1'b1;
                    end
                end
                ST_DOT: begin
                    if (is_sep_s) begin
                        store_v = 1'b1;
                        state_d = ST_SEP;
                    end else if (is_nl_s) begin
                        store_v = 1'b1;
                        eor_v   = 1'b1;
                        state_d = ST_SEP;
                    end else begin
                        err_v = 1'b1;
                    end
                end
                ST_ERR: begin
                    if (is_nl_s) begin
                        row_d    = {ROW_W{1'b0}};
                        col_d    = {COL_W{1'b0}};
                        shadow_d = {BOARD_W{1'b0}};
                        state_d  = ST_SEP;
                    end else begin
                        state_d  = ST_ERR;
                    end
                end
                default: begin
                    err_v = 1'b1;
                end
            endcase
        end else begin
            busy_d = busy_q;
        end

        // Store a completed field; a field beyond the last column is an error.
        if (store_v) begin
            if (col_q == COLS_C) begin
                err_v = 1'b1;
            end else begin
                shadow_d[CELL_W*cell_idx_s +: CELL_W] = store_val_v;
                col_v = col_q + COL_W'(1);
                col_d = col_v;
            end
        end else begin
            col_v = col_q;
        end

        // End-of-row check sees the column count after this character's store.
        if (eor_v && !err_v) begin
            if (col_v != COLS_C) begin
                err_v = 1'b1;
            end else if (row_q == LAST_ROW_C) begin
                board_d       = shadow_d;
                board_valid_d = 1'b1;
                shadow_d      = {BOARD_W{1'b0}};
                row_d         = {ROW_W{1'b0}};
                col_d         = {COL_W{1'b0}};
                busy_d        = 1'b0;
            end else begin
                row_d = row_q + ROW_W'(1);
                col_d = {COL_W{1'b0}};
            end
        end else begin
            eor_v = 1'b0;
        end

        // Abort the frame; a newline resynchronises at once, else wait for one.
        if (err_v) begin
            parse_err_d = 1'b1;
            shadow_d    = {BOARD_W{1'b0}};
            acc_d       = {CELL_W{1'b0}};
            row_d       = {ROW_W{1'b0}};
            col_d       = {COL_W{1'b0}};
            busy_d      = 1'b0;
            state_d     = is_nl_s ? ST_SEP : ST_ERR;
        end else begin
            parse_err_d = 1'b0;
        end
    end

    // Parser state and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SEP;
            acc_q         <= {CELL_W{1'b0}};
            row_q         <= {ROW_W{1'b0}};
            col_q         <= {COL_W{1'b0}};
            shadow_q      <= {BOARD_W{1'b0}};
            board_q       <= {BOARD_W{1'b0}};
            board_valid_q <= 1'b0;
            parse_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            row_q         <= row_d;
            col_q         <= col_d;
            shadow_q      <= shadow_d;
            board_q       <= board_d;
            board_valid_q <= board_valid_d;
            parse_err_q   <= parse_err_d;
            busy_q        <= busy_d;
        end
    end

    assign board       = board_q;
    assign board_valid = board_valid_q;
    assign parse_err   = parse_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_string_to_board.sv
// Testbench for string_to_board. It feeds directed character streams and
// checks every output on every cycle against a line/token based reference
// model. Hand-written boards at key points pin the model itself.
module tb_string_to_board;

    localparam int     ROWS   = 4;
    localparam int     COLS   = 4;
    localparam int     CELL_W = 20;
    localparam int     BW     = ROWS * COLS * CELL_W;
    localparam longint MAXV   = (longint'(1) << CELL_W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    char_in;
    logic          char_valid;
    logic [BW-1:0] board;
    logic          board_valid;
    logic          parse_err;
    logic          busy;

    string_to_board #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .board       (board),
        .board_valid (board_valid),
        .parse_err   (parse_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int bv_cnt = 0;
    int pe_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model state: text of the current line, completed cell values
    // of the frame so far, and whether the rest of an aborted line is skipped.
    logic [BW-1:0] exp_board;
    bit            exp_bv, exp_pe, exp_busy;
    string         m_line;
    int            m_cells[$];
    bit            m_disc;
    string         toks[$];

    function automatic bit is_sepc(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h7C);
    endfunction

    // Value of a field token, or -1 if it is not a legal (partial) field.
    function automatic longint tok_val(input string t);
        longint     v;
        logic [7:0] ch;
        v = 0;
        if (t == ".") return 0;
        if (t.len() == 0) return -1;
        for (int i = 0; i < t.len(); i++) begin
            ch = t[i];
            if (ch < 8'h30 || ch > 8'h39) return -1;
            v = v * 10 + longint'(ch - 8'h30);
            if (v > MAXV) return -1;
        end
        return v;
    endfunction

    task automatic split(input string s);
        string      cur;
        logic [7:0] ch;
        cur = "";
        toks.delete();
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (is_sepc(ch)) begin
                if (cur.len() > 0) toks.push_back(cur);
                cur = "";
            end else begin
                cur = $sformatf("%s%c", cur, ch);
            end
        end
        if (cur.len() > 0) toks.push_back(cur);
    endtask

    task automatic model_reset();
        exp_board = '0;
        exp_bv    = 1'b0;
        exp_pe    = 1'b0;
        exp_busy  = 1'b0;
        m_line    = "";
        m_disc    = 1'b0;
        m_cells.delete();
    endtask

    task automatic model_err();
        exp_pe = 1'b1;
        m_line = "";
        m_cells.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] c);
        bit ok;
        exp_bv = 1'b0;
        exp_pe = 1'b0;
        if (v && c != 8'h0D) begin
            if (m_disc) begin
                if (c == 8'h0A) m_disc = 1'b0;
            end else if (c == 8'h0A) begin
                split(m_line);
                m_line = "";
                if (toks.size() != 0) begin
                    ok = (toks.size() == COLS);
                    foreach (toks[i]) if (tok_val(toks[i]) < 0) ok = 1'b0;
                    if (!ok) begin
                        model_err();
                    end else begin
                        foreach (toks[i]) m_cells.push_back(int'(tok_val(toks[i])));
                        if (m_cells.size() == ROWS * COLS) begin
                            for (int i = 0; i < ROWS * COLS; i++)
                                exp_board[CELL_W*i +: CELL_W] = CELL_W'(m_cells[i]);
                            exp_bv = 1'b1;
                            m_cells.delete();
                        end
                    end
                end
            end else begin
                m_line = $sformatf("%s%c", m_line, c);
                split(m_line);
                ok = 1'b1;
                foreach (toks[i]) if (tok_val(toks[i]) < 0) ok = 1'b0;
                if (is_sepc(c) && toks.size() > COLS) ok = 1'b0;
                if (!ok) begin
                    model_err();
                    m_disc = 1'b1;
                end
            end
        end
        exp_busy = !m_disc && (m_cells.size() != 0 || m_line.len() != 0);
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (board !== exp_board) begin
                n_fail++;
                $display("FAIL board @%0t: got %h want %h", $time, board, exp_board);
            end
            n_vec++;
            if (board_valid !== exp_bv) begin
                n_fail++;
                $display("FAIL board_valid @%0t: got %b want %b", $time, board_valid, exp_bv);
            end
            n_vec++;
            if (parse_err !== exp_pe) begin
                n_fail++;
                $display("FAIL parse_err @%0t: got %b want %b", $time, parse_err, exp_pe);
            end
            n_vec++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy @%0t: got %b want %b", $time, busy, exp_busy);
            end
            bv_cnt += int'(board_valid);
            pe_cnt += int'(parse_err);
        end
    end

    task automatic hand_chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick(input bit r, input bit v, input logic [7:0] c);
        @(negedge clk);
        rst        = r;
        char_valid = v;
        char_in    = c;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(v, c);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'h78);
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 8'h78);
            tick(1'b0, 1'b1, s[i]);
        end
    endtask

    string         s1, s2, sg2, s5a, s5b;
    logic [BW-1:0] g1, g2, g5;
    int            bv0, pe0;

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;

        s1  = "2 . . 4\n. 8 . .\n. . 16 .\n2048 . . 2\n";
        s2  = "\r\n|2|.|.|4|\r\n  . | 8 |.|.  \r\n|.||.|16|.|\r\n2048  .  .  2\r\n";
        sg2 = "1 2 3 4\n5 6 7 8\n9 10 11 12\n13 14 15 16\n";
        s5a = "1048575 . . .\n. . . .\n. . . .\n. . . .\n";
        s5b = ". . . .\n1048576 . . .\n";

        g1 = '0;
        g1[CELL_W*0  +: CELL_W] = 20'd2;
        g1[CELL_W*3  +: CELL_W] = 20'd4;
        g1[CELL_W*5  +: CELL_W] = 20'd8;
        g1[CELL_W*10 +: CELL_W] = 20'd16;
        g1[CELL_W*12 +: CELL_W] = 20'd2048;
        g1[CELL_W*15 +: CELL_W] = 20'd2;
        g2 = '0;
        for (int i = 0; i < ROWS * COLS; i++) g2[CELL_W*i +: CELL_W] = CELL_W'(i + 1);
        g5 = '0;
        g5[CELL_W*0 +: CELL_W] = 20'hFFFFF;

        // Reset state
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk_en = 1'b1;
        #1;
        hand_chk("reset_board", board, '0);
        hand_chk("reset_busy", BW'(busy), '0);

        // 1: back-to-back frame
        bv0 = bv_cnt;
        send_str(s1, 1'b0);
        idle(2);
        #1;
        hand_chk("s1_board", board, g1);
        hand_chk("s1_bv_count", BW'(bv_cnt - bv0), BW'(1));
        hand_chk("s1_busy", BW'(busy), '0);

        // 2: pipes, CRLF, doubled spaces, leading blank line, gaps
        tick(1'b1, 1'b0, 8'h00);
        bv0 = bv_cnt;
        pe0 = pe_cnt;
        send_str(s2, 1'b1);
        idle(2);
        #1;
        hand_chk("s2_board", board, g1);
        hand_chk("s2_bv_count", BW'(bv_cnt - bv0), BW'(1));
        hand_chk("s2_pe_count", BW'(pe_cnt - pe0), '0);

        // 3: short row 2, then a good frame
        pe0 = pe_cnt;
        send_str("2 . . 4\n. 8 . .\n. . 16\n", 1'b0);
        idle(1);
        #1;
        hand_chk("s3_board_kept", board, g1);
        hand_chk("s3_pe_count", BW'(pe_cnt - pe0), BW'(1));
        hand_chk("s3_busy", BW'(busy), '0);
        send_str(sg2, 1'b0);
        idle(1);
        #1;
        hand_chk("s3_next_board", board, g2);

        // 4: bad character mid row 1, rest of line skipped, then a good frame
        pe0 = pe_cnt;
        send_str("2 . . 4\n. 8 x . 99 .\n", 1'b0);
        idle(1);
        #1;
        hand_chk("s4_pe_count", BW'(pe_cnt - pe0), BW'(1));
        hand_chk("s4_board_kept", board, g2);
        send_str(s1, 1'b0);
        idle(1);
        #1;
        hand_chk("s4_next_board", board, g1);

        // 5: largest cell value, then one past it
        send_str(s5a, 1'b0);
        idle(1);
        #1;
        hand_chk("s5_max_board", board, g5);
        pe0 = pe_cnt;
        send_str(s5b, 1'b0);
        idle(1);
        #1;
        hand_chk("s5_ovf_pe_count", BW'(pe_cnt - pe0), BW'(1));
        hand_chk("s5_ovf_board", board, g5);

        // 6: reset after two rows, then a full frame
        bv0 = bv_cnt;
        send_str("1 2 3 4\n5 6 7 8\n", 1'b0);
        tick(1'b1, 1'b0, 8'h00);
        idle(1);
        #1;
        hand_chk("s6_board", board, '0);
        hand_chk("s6_busy", BW'(busy), '0);
        hand_chk("s6_bv_count", BW'(bv_cnt - bv0), '0);
        send_str(sg2, 1'b0);
        idle(2);
        #1;
        hand_chk("s6_next_board", board, g2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
